idu_stage: RTL and testbench
============================

// Module: idu_stage
// PURPOSE
//  - Decode-stage controller between IFU and EXU of the NPC core. Accepts fetched instructions over valid/ready.
//  - Classifies the opcode, selects the ext_op for immediate generation and extracts the register fields.
//  - Buffers decoded bundles in a 2-entry skid queue, so in_ready is registered and throughput is 1 inst/cycle.
//  - Supports flush on branch/jump redirect.
// PARAMETERS
//  XLEN      32  datapath width; only 32 is supported
//  DEPTH     2   skid-queue entries; fixed, any other value is an elaboration error
// PORTS
//  clk        in   1   system clock, all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  flush      in   1   redirect: discard every buffered and incoming inst this cycle
//  in_valid   in   1   IFU has an instruction
//  in_ready   out  1   queue can accept (registered, = ~full)
//  in_inst    in   32  instruction word
//  in_pc      in   32  instruction PC
//  out_valid  out  1   head entry valid
//  out_ready  in   1   EXU accepts head
//  out_pc     out  32  head PC
//  out_imm    out  32  head sign-extended immediate
//  out_ext_op out  3   head imm format: I=0 U=1 B=2 J=3 S=4
//  out_rd/out_rs1/out_rs2 out 5 each  inst[11:7], inst[19:15], inst[24:20]
//  out_has_imm out 1   0 for R-type and illegal
//  out_illegal out 1   opcode not in the supported RV32I set
// BEHAVIOUR
//  - Handshakes: enq = in_valid&in_ready&~flush; deq = out_valid&out_ready&~flush.
//  - Once asserted, in_valid may not drop, and in_inst/in_pc may not change, until enq.
//  - Opcode map (inst[6:0]):
//      0010011/0000011/1100111/1110011 -> ext_op 0;  0110111/0010111 -> 1;  1100011 -> 2;
//      1101111 -> 3;  0100011 -> 4;  0110011 -> ext_op 0, has_imm 0;
//      anything else -> illegal=1, ext_op 0, has_imm 0, imm 0.
//  - Immediates (bit 31 always = inst[31]):
//      I {20{i31},i[31:20]};  S {20{i31},i[31:25],i[11:7]};  B {20{i31},i[7],i[30:25],i[11:8],0};
//      U {i[31:12],12'b0};  J {12{i31},i[19:12],i[20],i[30:21],0}.
//  - Decode is combinational on in_inst. The full bundle is written at enq, so latency in->out is 1 cycle minimum.
//  - Queue: wr_ptr, rd_ptr (1 bit each), count 0..2. States EMPTY(0), ONE(1), FULL(2):
//      EMPTY: enq -> ONE.
//      ONE: enq&~deq -> FULL;  deq&~enq -> EMPTY;  enq&deq -> ONE (head advances).
//      FULL: deq -> ONE; no enq possible.
//  - out_valid = (count!=0). Out fields come from entry[rd_ptr] and must not change while out_valid&~out_ready.
//  - in_ready = (count!=2). Registered: in_ready is 0 while rst=1 and 1 in the first cycle after reset.
//  - flush: next count=0, both pointers=0. Flush dominates same-cycle enq/deq, so nothing is enqueued or dequeued.
//    out_valid=0 and in_ready=1 in the next cycle.
//  - Reset mid-operation: same as flush plus in_ready=0 during rst; every out_* data field resets to 0.
//  - Pointer wrap 1->0 is natural 1-bit overflow; count never exceeds 2. Assert (SVA) no enq when count==2.
// STRUCTURE
//  - Shared package npc_pkg: EXT_I/U/B/J/S localparams (3-bit), OPC_* opcode constants, decoded-bundle field widths.
//  - Sub-module idu_decode (combinational): inst -> {ext_op, imm, has_imm, illegal}.
//  - idu_stage holds only the queue, pointers, count and handshake logic.
// TESTING
//  1 addi x1,x0,-1 (0xfff00093), out_ready=1 -> next cycle out_valid=1, ext_op=0, imm=0xffffffff, rd=1, rs1=0.
//  2 lui 0x12345037 then jal 0x0080006f back-to-back:
//      ext_op 1/imm 0x12345000, then ext_op 3/imm 0x00000008, on consecutive cycles.
//  3 beq 0xfe000ee3 -> ext_op=2, imm=0xfffffffc; sw 0x0020a223 -> ext_op=4, imm=4, rs1=1, rs2=2.
//  4 out_ready=0, push 3 insts -> in_ready drops after the 2nd enq, 3rd stalls;
//      raise out_ready -> all 3 delivered in order, no loss or duplicate.
//  5 queue FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed inst never appears.
//  6 0x0000000b (custom opcode) -> illegal=1, has_imm=0, imm=0;
//      rst asserted mid-stream -> all outputs 0 and in_ready=0 while rst=1.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared decode-stage types and constants for the NPC core: opcode map, imm formats, decoded bundle.
// Pure definitions; no latency or flow control of its own.
package npc_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int EXT_W  = 3;

  localparam logic [EXT_W-1:0] EXT_I = 3'd0;
  localparam logic [EXT_W-1:0] EXT_U = 3'd1;
  localparam logic [EXT_W-1:0] EXT_B = 3'd2;
  localparam logic [EXT_W-1:0] EXT_J = 3'd3;
  localparam logic [EXT_W-1:0] EXT_S = 3'd4;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [EXT_W-1:0]  ext_op;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic              has_imm;
    logic              illegal;
  } bundle_t;

endpackage

// File: rtl/idu_decode.sv
// Opcode classifier and immediate generator; purely combinational, zero latency, no flow control.
// Unsupported opcodes and R-type report has_imm=0 with a zero immediate.
module idu_decode
  import npc_pkg::*;
(
  input  logic [DATA_W-1:0] inst,
  output logic [EXT_W-1:0]  ext_op,
  output logic [DATA_W-1:0] imm,
  output logic              has_imm,
  output logic              illegal
);

  always_comb begin
    ext_op  = EXT_I;
    has_imm = 1'b1;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: ext_op = EXT_I;
      OPC_LUI, OPC_AUIPC:                         ext_op = EXT_U;
      OPC_BRANCH:                                 ext_op = EXT_B;
      OPC_JAL:                                    ext_op = EXT_J;
      OPC_STORE:                                  ext_op = EXT_S;
      OPC_OP:                                     has_imm = 1'b0;
      default: begin
        has_imm = 1'b0;
        illegal = 1'b1;
      end
    endcase

    case (ext_op)
      EXT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      EXT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      EXT_B:   imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      EXT_U:   imm = {inst[31:12], 12'b0};
      EXT_J:   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    if (!has_imm) imm = '0;
  end

endmodule

// File: rtl/idu_stage.sv
// Decode stage: classifies fetched insts into a 2-entry skid queue; 1-cycle in->out, 1 inst/cycle.
// in_ready is ~full of the registered queue state (held low in reset); flush empties the queue.
module idu_stage
  import npc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [EXT_W-1:0] out_ext_op,
  output logic [REG_W-1:0] out_rd,
  output logic [REG_W-1:0] out_rs1,
  output logic [REG_W-1:0] out_rs2,
  output logic             out_has_imm,
  output logic             out_illegal
);

  if (XLEN != 32 || DEPTH != 2) begin : g_param_check
    $error("idu_stage supports only XLEN=32 and DEPTH=2");
  end

  logic [EXT_W-1:0]  dec_ext_op;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_has_imm;
  logic              dec_illegal;

  idu_decode u_decode (
    .inst    (in_inst),
    .ext_op  (dec_ext_op),
    .imm     (dec_imm),
    .has_imm (dec_has_imm),
    .illegal (dec_illegal)
  );

  q_state_t state;
  logic     wr_ptr;
  logic     rd_ptr;
  bundle_t  mem [2];
  bundle_t  wr_bundle;
  bundle_t  head;
  logic     enq;
  logic     deq;

  always_comb begin
    wr_bundle         = '0;
    wr_bundle.pc      = in_pc;
    wr_bundle.imm     = dec_imm;
    wr_bundle.ext_op  = dec_ext_op;
    wr_bundle.rd      = in_inst[11:7];
    wr_bundle.rs1     = in_inst[19:15];
    wr_bundle.rs2     = in_inst[24:20];
    wr_bundle.has_imm = dec_has_imm;
    wr_bundle.illegal = dec_illegal;
  end

  // in_ready comes straight from registered state; rst only masks it low.
  assign in_ready  = (state != Q_FULL) && !rst;
  assign out_valid = (state != Q_EMPTY);
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= Q_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      state  <= Q_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= wr_bundle;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case (state)
        Q_EMPTY: if (enq) state <= Q_ONE;
        Q_ONE: begin
          if (enq && !deq)      state <= Q_FULL;
          else if (deq && !enq) state <= Q_EMPTY;
        end
        Q_FULL:  if (deq) state <= Q_ONE;
        default: state <= Q_EMPTY;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign out_pc      = head.pc;
  assign out_imm     = head.imm;
  assign out_ext_op  = head.ext_op;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_has_imm = head.has_imm;
  assign out_illegal = head.illegal;

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (rst) !(enq && state == Q_FULL));

endmodule

// File: tb/tb_idu_stage.sv
// Self-checking bench for idu_stage: directed scenarios plus randomized traffic against a queue model.
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [2:0]  out_ext_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_has_imm, out_illegal;

  idu_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_ext_op(out_ext_op), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_has_imm(out_has_imm), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  ext_op;
    logic [4:0]  rd, rs1, rs2;
    logic        has_imm, illegal;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  logic [31:0] pend_inst[$];
  logic [31:0] pend_pc[$];
  logic        last_enq;

  // Reference decode built with shifts and masks on the whole word.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    logic signed [31:0] s;
    s         = inst;
    e.pc      = pc;
    e.rd      = 5'((inst >> 7) & 32'h1f);
    e.rs1     = 5'((inst >> 15) & 32'h1f);
    e.rs2     = 5'((inst >> 20) & 32'h1f);
    e.has_imm = 1'b1;
    e.illegal = 1'b0;
    e.ext_op  = 3'd0;
    e.imm     = 32'(s >>> 20);
    case (inst & 32'h7f)
      32'h13, 32'h03, 32'h67, 32'h73: ;
      32'h37, 32'h17: begin e.ext_op = 3'd1; e.imm = inst & 32'hfffff000; end
      32'h63: begin
        e.ext_op = 3'd2;
        e.imm = (32'(s >>> 19) & 32'hfffff000) | ((inst & 32'h80) << 4) |
                ((inst >> 20) & 32'h7e0) | ((inst >> 7) & 32'h1e);
      end
      32'h6f: begin
        e.ext_op = 3'd3;
        e.imm = (32'(s >>> 11) & 32'hfff00000) | (inst & 32'h000ff000) |
                ((inst >> 9) & 32'h800) | ((inst >> 20) & 32'h7fe);
      end
      32'h23: begin
        e.ext_op = 3'd4;
        e.imm = (32'(s >>> 20) & ~32'h1f) | ((inst >> 7) & 32'h1f);
      end
      32'h33: begin e.has_imm = 1'b0; e.imm = 32'h0; end
      default: begin e.has_imm = 1'b0; e.illegal = 1'b1; e.imm = 32'h0; end
    endcase
    return e;
  endfunction

  // Drive the next pending inst, advance one clock, and update the model queue.
  task automatic step();
    logic enq, deq;
    in_valid = (pend_inst.size() != 0);
    in_inst  = in_valid ? pend_inst[0] : 32'h0;
    in_pc    = in_valid ? pend_pc[0]   : 32'h0;
    enq = in_valid && (exp_q.size() < 2) && !flush && !rst;
    deq = (exp_q.size() != 0) && out_ready && !flush && !rst;
    @(posedge clk);
    if (rst || flush) exp_q.delete();
    else begin
      if (deq) void'(exp_q.pop_front());
      if (enq) exp_q.push_back(ref_decode(in_inst, in_pc));
    end
    #1;
    last_enq = enq;
    if (enq) begin
      void'(pend_inst.pop_front());
      void'(pend_pc.pop_front());
    end
    in_valid = (pend_inst.size() != 0);
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    pend_inst.push_back(inst);
    pend_pc.push_back(pc);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if ({out_pc, out_imm} !== 64'h0) begin n_fail++; $display("FAIL reset_pc_imm: got %h %h want 0", out_pc, out_imm); end
    n_checks++; if ({out_ext_op, out_rd, out_rs1, out_rs2, out_has_imm, out_illegal} !== 20'h0) begin
      n_fail++; $display("FAIL reset_fields: got %h %h %h %h %b %b want 0", out_ext_op, out_rd, out_rs1, out_rs2, out_has_imm, out_illegal);
    end
    rst = 1'b0; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    push(32'hfff00093, 32'h80000000);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_pre_valid: got %b want 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    n_checks++; if (out_ext_op !== 3'd0) begin n_fail++; $display("FAIL addi_ext_op: got %0d want 0", out_ext_op); end
    n_checks++; if (out_imm !== 32'hffffffff) begin n_fail++; $display("FAIL addi_imm: got %h want ffffffff", out_imm); end
    n_checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0) begin n_fail++; $display("FAIL addi_regs: got rd=%0d rs1=%0d want 1 0", out_rd, out_rs1); end
    n_checks++; if (out_pc !== 32'h80000000) begin n_fail++; $display("FAIL addi_pc: got %h want 80000000", out_pc); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    push(32'h12345037, 32'h100);
    push(32'h0080006f, 32'h104);
    step();
    n_checks++; if (out_valid !== 1'b1 || out_ext_op !== 3'd1 || out_imm !== 32'h12345000 || out_pc !== 32'h100) begin
      n_fail++; $display("FAIL lui: got v=%b ext=%0d imm=%h pc=%h want 1 1 12345000 100", out_valid, out_ext_op, out_imm, out_pc);
    end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_ext_op !== 3'd3 || out_imm !== 32'h8 || out_pc !== 32'h104) begin
      n_fail++; $display("FAIL jal: got v=%b ext=%0d imm=%h pc=%h want 1 3 00000008 104", out_valid, out_ext_op, out_imm, out_pc);
    end
    step();
  endtask

  task automatic test_branch_store();
    out_ready = 1'b1;
    push(32'hfe000ee3, 32'h200);
    push(32'h0020a223, 32'h204);
    step();
    n_checks++; if (out_ext_op !== 3'd2 || out_imm !== 32'hfffffffc) begin
      n_fail++; $display("FAIL beq: got ext=%0d imm=%h want 2 fffffffc", out_ext_op, out_imm);
    end
    step();
    n_checks++; if (out_ext_op !== 3'd4 || out_imm !== 32'h4 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin
      n_fail++; $display("FAIL sw: got ext=%0d imm=%h rs1=%0d rs2=%0d want 4 4 1 2", out_ext_op, out_imm, out_rs1, out_rs2);
    end
    step();
  endtask

  task automatic test_stall();
    logic [31:0] got[$];
    out_ready = 1'b0;
    push(32'h00100093, 32'h300);
    push(32'h00200113, 32'h304);
    push(32'h00300193, 32'h308);
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_one: got %b want 1", in_ready); end
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_full: got %b want 0", in_ready); end
    step(); step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold: got v=%b pc=%h rdy=%b want 1 300 0", out_valid, out_pc, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) got.push_back(out_pc);
      step();
    end
    n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL stall_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_checks++; if (got[i] !== 32'h300 + 32'(4 * i)) begin
        n_fail++; $display("FAIL stall_order[%0d]: got %h want %h", i, got[i], 32'h300 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(32'h00100093, 32'h400);
    push(32'h00200113, 32'h404);
    step(); step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %b want 0", in_ready); end
    push(32'h00300193, 32'h40c);
    flush = 1'b1;
    step();
    flush = 1'b0;
    pend_inst.delete(); pend_pc.delete();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_after: got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: got v=%b pc=%h want 0", i, out_valid, out_pc); end
    end
  endtask

  task automatic test_illegal_and_reset();
    out_ready = 1'b1;
    push(32'h0000000b, 32'h500);
    step();
    n_checks++; if (out_illegal !== 1'b1 || out_has_imm !== 1'b0 || out_imm !== 32'h0 || out_ext_op !== 3'd0) begin
      n_fail++; $display("FAIL illegal: got ill=%b hi=%b imm=%h ext=%0d want 1 0 0 0", out_illegal, out_has_imm, out_imm, out_ext_op);
    end
    step();
    out_ready = 1'b0;
    push(32'hfff00093, 32'h600);
    push(32'h12345037, 32'h604);
    push(32'h0080006f, 32'h608);
    step(); step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    rst = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_hs: got v=%b rdy=%b want 0 0", out_valid, in_ready);
    end
    n_checks++; if ({out_pc, out_imm, out_ext_op, out_rd, out_rs1, out_rs2, out_has_imm, out_illegal} !== 84'h0) begin
      n_fail++; $display("FAIL mid_rst_data: got pc=%h imm=%h ext=%0d rd=%0d want 0", out_pc, out_imm, out_ext_op, out_rd);
    end
    pend_inst.delete(); pend_pc.delete();
    rst = 1'b0; #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_release: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
    step();
  endtask

  task automatic test_random();
    logic [6:0]  ops[11];
    logic [31:0] r;
    logic [31:0] pc = 32'h1000;
    exp_t        h;
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h37, 7'h17, 7'h63, 7'h6f, 7'h23, 7'h33, 7'h0b};
    for (int i = 0; i < 400; i++) begin
      if (pend_inst.size() == 0 && $urandom_range(0, 2) != 0) begin
        r = $urandom();
        push({r[31:7], ($urandom_range(0, 7) == 0) ? 7'(r[6:0]) : ops[$urandom_range(0, 10)]}, pc);
        pc += 32'd4;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      n_checks++; if (out_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, exp_q.size() != 0); end
      n_checks++; if (in_ready !== (exp_q.size() != 2)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, exp_q.size() != 2); end
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        n_checks++; if (out_pc !== h.pc || out_ext_op !== h.ext_op || out_has_imm !== h.has_imm || out_illegal !== h.illegal) begin
          n_fail++; $display("FAIL rnd_head[%0d]: got pc=%h ext=%0d hi=%b ill=%b want %h %0d %b %b", i, out_pc, out_ext_op, out_has_imm, out_illegal, h.pc, h.ext_op, h.has_imm, h.illegal);
        end
        n_checks++; if (out_rd !== h.rd || out_rs1 !== h.rs1 || out_rs2 !== h.rs2) begin
          n_fail++; $display("FAIL rnd_regs[%0d]: got %0d %0d %0d want %0d %0d %0d", i, out_rd, out_rs1, out_rs2, h.rd, h.rs1, h.rs2);
        end
        if (h.has_imm || h.illegal) begin
          n_checks++; if (out_imm !== h.imm) begin n_fail++; $display("FAIL rnd_imm[%0d]: got %h want %h", i, out_imm, h.imm); end
        end
      end
      step();
      if (flush) begin
        pend_inst.delete(); pend_pc.delete();
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch_store();
    test_stall();
    test_flush();
    test_illegal_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
